// File: rtl/lock_pkg.sv
// Shared state encoding and seven-segment digit codes for the serial combination lock.
package lock_pkg;

    typedef enum logic [1:0] {
        ENTER = 2'd0,
        OPEN  = 2'd1,
        LOCK  = 2'd2
    } lock_state_t;

    localparam logic [3:0] BLANK = 4'd10;
    localparam logic [3:0] O     = 4'd12;
    localparam logic [3:0] P     = 4'd13;
    localparam logic [3:0] E     = 4'd14;
    localparam logic [3:0] N     = 4'd15;

endpackage

// File: rtl/btn_event.sv
// Button front end: synchronises the raw active-low press and the code bit, and turns
// each accepted falling edge into a one-cycle event followed by a hold-off window.
module btn_event #(
    parameter int HOLD_CYC = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic press,
    input  logic bit_in,
    output logic press_evt,
    output logic bit_sync
);

    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);

    logic          press_s1;
    logic          press_s2;
    logic          press_prev;
    logic          bit_s1;
    logic [HW-1:0] hold_cnt;

    // The press chain resets to the released level so reset release never looks like a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_s1   <= 1'b1;
            press_s2   <= 1'b1;
            press_prev <= 1'b1;
            bit_s1     <= 1'b0;
            bit_sync   <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            press_s1   <= press;
            press_s2   <= press_s1;
            press_prev <= press_s2;
            bit_s1     <= bit_in;
            bit_sync   <= bit_s1;
            if (press_evt) begin
                hold_cnt <= HOLD_LOAD;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    assign press_evt = press_prev & ~press_s2 & (hold_cnt == '0);

endmodule

// File: rtl/combo_lock_ctrl.sv
// Serial combination lock: bit-per-press code entry, failure counting with timed lockout,
// and a PWM-dimmed six-digit status display.
module combo_lock_ctrl
    import lock_pkg::*;
#(
    parameter int                  CODE_LEN   = 7,
    parameter logic [CODE_LEN-1:0] CODE       = 7'b1010100,
    parameter int                  MAX_FAIL   = 3,
    parameter int                  LOCK_CYC   = 50_000_000,
    parameter int                  HOLD_CYC   = 500_000,
    parameter int                  PWM_PERIOD = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          press,
    input  logic                          bit_in,
    input  logic [3:0]                    bright,
    output logic [3:0]                    num0,
    output logic [3:0]                    num1,
    output logic [3:0]                    num2,
    output logic [3:0]                    num3,
    output logic [3:0]                    num4,
    output logic [3:0]                    num5,
    output logic                          unlocked,
    output logic                          lockout,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int CW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int LW = $clog2(LOCK_CYC + 1);
    localparam int PW = $clog2(PWM_PERIOD + 1);
    localparam int BW = (PW > 4) ? PW : 4;

    localparam logic [CW-1:0] CODE_CNT  = CW'(CODE_LEN);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_CYC - 1);
    localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_PERIOD - 1);

    lock_state_t         state;
    logic [CODE_LEN-1:0] shift_reg;
    logic [CODE_LEN-1:0] shift_next;
    logic [CW-1:0]       entry_cnt;
    logic [CW-1:0]       entry_next;
    logic [FW-1:0]       fail_next;
    logic [LW-1:0]       lock_cnt;
    logic [PW-1:0]       pwm_cnt;
    logic                press_evt;
    logic                bit_sync;
    logic                display_on;
    logic [3:0]          digit [6];

    btn_event #(
        .HOLD_CYC (HOLD_CYC)
    ) u_btn_event (
        .clk       (clk),
        .rst       (rst),
        .press     (press),
        .bit_in    (bit_in),
        .press_evt (press_evt),
        .bit_sync  (bit_sync)
    );

    assign shift_next = (shift_reg << 1) | CODE_LEN'(bit_sync);
    assign entry_next = entry_cnt + 1'b1;
    assign fail_next  = fail_cnt + 1'b1;

    // The comparison uses the shifted-in value so the last bit counts in its own event cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ENTER;
            shift_reg <= '0;
            entry_cnt <= '0;
            fail_cnt  <= '0;
            lock_cnt  <= '0;
            unlocked  <= 1'b0;
            lockout   <= 1'b0;
        end else begin
            case (state)
                ENTER: begin
                    if (press_evt) begin
                        shift_reg <= shift_next;
                        if (entry_next == CODE_CNT) begin
                            if (shift_next == CODE) begin
                                state     <= OPEN;
                                unlocked  <= 1'b1;
                                fail_cnt  <= '0;
                                entry_cnt <= entry_next;
                            end else begin
                                entry_cnt <= '0;
                                fail_cnt  <= fail_next;
                                if (fail_next == FAIL_MAX) begin
                                    state    <= LOCK;
                                    lockout  <= 1'b1;
                                    lock_cnt <= LOCK_LOAD;
                                end
                            end
                        end else begin
                            entry_cnt <= entry_next;
                        end
                    end
                end
                OPEN: begin
                    if (press_evt) begin
                        state     <= ENTER;
                        unlocked  <= 1'b0;
                        shift_reg <= '0;
                        entry_cnt <= '0;
                    end
                end
                LOCK: begin
                    if (lock_cnt == '0) begin
                        state     <= ENTER;
                        lockout   <= 1'b0;
                        fail_cnt  <= '0;
                        entry_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ENTER;
                end
            endcase
        end
    end

    // Values of bright beyond the period simply never reach the off threshold.
    assign display_on = BW'(pwm_cnt) < BW'(bright);

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            digit[i] = BLANK;
        end
        if (display_on) begin
            case (state)
                ENTER: digit[0] = 4'(entry_cnt);
                OPEN: begin
                    digit[5] = O;
                    digit[4] = P;
                    digit[3] = E;
                    digit[2] = N;
                    digit[0] = 4'(CODE_LEN);
                end
                LOCK: begin
                    digit[5] = E;
                    digit[0] = 4'(fail_cnt);
                end
                default: digit[0] = BLANK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt <= '0;
            num0    <= 4'd0;
            num1    <= BLANK;
            num2    <= BLANK;
            num3    <= BLANK;
            num4    <= BLANK;
            num5    <= BLANK;
        end else begin
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
            num0    <= digit[0];
            num1    <= digit[1];
            num2    <= digit[2];
            num3    <= digit[3];
            num4    <= digit[4];
            num5    <= digit[5];
        end
    end

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed bench for combo_lock_ctrl: entry, failures and lockout, bounce rejection,
// relock, PWM dimming and asynchronous reset mid-entry and mid-lockout.
module tb_combo_lock_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        press;
    logic        bit_in;
    logic [3:0]  bright;
    logic [3:0]  num0, num1, num2, num3, num4, num5;
    logic        unlocked;
    logic        lockout;
    logic [1:0]  fail_cnt;
    logic [23:0] nums;
    int          checks = 0;
    int          errors = 0;
    int          on_cnt;
    int          upper_bad;

    assign nums = {num5, num4, num3, num2, num1, num0};

    always #5 clk = ~clk;

    combo_lock_ctrl #(
        .CODE_LEN   (7),
        .CODE       (7'b1010100),
        .MAX_FAIL   (3),
        .LOCK_CYC   (100),
        .HOLD_CYC   (8),
        .PWM_PERIOD (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .press    (press),
        .bit_in   (bit_in),
        .bright   (bright),
        .num0     (num0),
        .num1     (num1),
        .num2     (num2),
        .num3     (num3),
        .num4     (num4),
        .num5     (num5),
        .unlocked (unlocked),
        .lockout  (lockout),
        .fail_cnt (fail_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_nums(input string tag, input logic [23:0] exp);
        check(tag, 32'(nums), 32'(exp));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One clean press: the event lands on the 3rd posedge, then the hold-off fully expires.
    task automatic press_bit(input logic b);
        @(negedge clk);
        bit_in = b;
        press  = 1'b0;
        repeat (3) @(negedge clk);
        press = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic enter_bits(input logic [6:0] bits);
        for (int i = 6; i >= 0; i--) begin
            press_bit(bits[i]);
        end
    endtask

    task automatic measure_pwm();
        on_cnt    = 0;
        upper_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (num0 !== 4'd10) on_cnt++;
            if (nums[23:4] !== 20'hAAAAA) upper_bad++;
        end
    endtask

    task automatic async_reset_pulse();
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    initial begin
        rst    = 1'b0;
        press  = 1'b1;
        bit_in = 1'b0;
        bright = 4'd10;
        idle(3);
        check_nums("reset_nums", 24'hAAAAA0);
        check("reset_unlocked", 32'(unlocked), 32'd0);
        check("reset_lockout", 32'(lockout), 32'd0);
        check("reset_fail", 32'(fail_cnt), 32'd0);
        rst = 1'b1;
        idle(3);
        check_nums("idle_nums", 24'hAAAAA0);

        press_bit(1'b1);
        press_bit(1'b0);
        press_bit(1'b1);
        press_bit(1'b0);
        check_nums("entry4_nums", 24'hAAAAA4);
        press_bit(1'b1);
        press_bit(1'b0);
        press_bit(1'b0);
        check("open_unlocked", 32'(unlocked), 32'd1);
        check_nums("open_nums", 24'hCDEFA7);
        check("open_fail", 32'(fail_cnt), 32'd0);
        check("open_lockout", 32'(lockout), 32'd0);

        press_bit(1'b0);
        check("relock_unlocked", 32'(unlocked), 32'd0);
        check_nums("relock_nums", 24'hAAAAA0);

        enter_bits(7'b1111111);
        check("fail1_cnt", 32'(fail_cnt), 32'd1);
        check_nums("fail1_nums", 24'hAAAAA0);
        enter_bits(7'b1111111);
        check("fail2_cnt", 32'(fail_cnt), 32'd2);
        check("fail2_lockout", 32'(lockout), 32'd0);
        enter_bits(7'b1111111);
        check("lock_lockout", 32'(lockout), 32'd1);
        check_nums("lock_nums", 24'hEAAAA3);
        check("lock_fail", 32'(fail_cnt), 32'd3);
        check("lock_unlocked", 32'(unlocked), 32'd0);

        // Lock entered 12 cycles ago; this press ends 28 cycles into the lockout.
        press_bit(1'b0);
        check_nums("lockpress_nums", 24'hEAAAA3);
        check("lockpress_lockout", 32'(lockout), 32'd1);
        idle(71);
        check("lock_last_cycle", 32'(lockout), 32'd1);
        idle(1);
        check("lock_release", 32'(lockout), 32'd0);
        check("release_fail", 32'(fail_cnt), 32'd0);
        idle(1);
        check_nums("release_nums", 24'hAAAAA0);

        @(negedge clk);
        bit_in = 1'b1;
        press  = 1'b0;
        @(negedge clk) press = 1'b1;
        @(negedge clk) press = 1'b0;
        @(negedge clk) press = 1'b1;
        @(negedge clk) press = 1'b0;
        @(negedge clk) press = 1'b1;
        idle(14);
        check_nums("bounce_nums", 24'hAAAAA1);
        press_bit(1'b1);
        check_nums("after_bounce_nums", 24'hAAAAA2);

        bright = 4'd3;
        idle(2);
        measure_pwm();
        check("pwm3_on", 32'(on_cnt), 32'd6);
        check("pwm3_upper", 32'(upper_bad), 32'd0);
        bright = 4'd0;
        idle(2);
        measure_pwm();
        check("pwm0_on", 32'(on_cnt), 32'd0);
        bright = 4'd12;
        idle(2);
        measure_pwm();
        check("pwm_full_on", 32'(on_cnt), 32'd20);
        bright = 4'd10;

        async_reset_pulse();
        idle(2);
        rst = 1'b1;
        idle(2);
        press_bit(1'b1);
        press_bit(1'b0);
        press_bit(1'b1);
        press_bit(1'b0);
        check_nums("mid_entry_nums", 24'hAAAAA4);
        async_reset_pulse();
        check_nums("async_entry_nums", 24'hAAAAA0);
        check("async_entry_unlocked", 32'(unlocked), 32'd0);
        idle(2);
        rst = 1'b1;
        idle(2);
        press_bit(1'b1);
        check_nums("post_reset_first", 24'hAAAAA1);
        press_bit(1'b0);
        press_bit(1'b1);
        press_bit(1'b0);
        press_bit(1'b1);
        press_bit(1'b0);
        press_bit(1'b0);
        check("post_reset_unlocked", 32'(unlocked), 32'd1);
        check_nums("post_reset_open_nums", 24'hCDEFA7);

        press_bit(1'b0);
        enter_bits(7'b1111111);
        enter_bits(7'b1111111);
        enter_bits(7'b1111111);
        check("lock2_lockout", 32'(lockout), 32'd1);
        async_reset_pulse();
        check("async_lock_lockout", 32'(lockout), 32'd0);
        check("async_lock_fail", 32'(fail_cnt), 32'd0);
        check_nums("async_lock_nums", 24'hAAAAA0);
        idle(2);
        rst = 1'b1;
        idle(2);
        press_bit(1'b1);
        check_nums("post_lock_reset_nums", 24'hAAAAA1);
        check("post_lock_reset_lockout", 32'(lockout), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
